// File: rtl/fifo_drain_if.sv
// ============================================================================
// fifo_drain_if : FIFO read port, valid/ready stream and flush for the drain controller
// Rev 1.0
// ============================================================================
`default_nettype none

interface fifo_drain_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data_out;
    logic              fifo_rd_en;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              flush;

    // master: the drain controller; slave: FIFO plus downstream consumer
    modport master (
        input  fifo_empty, fifo_data_out, m_ready, flush,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data_out, m_ready, flush,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
// ============================================================================
// fifo_drain_ctrl : drains a synchronous FIFO into a small buffer, re-presented as valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module fifo_drain_ctrl #(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fifo_drain_if.master          bus,
    output logic [CNT_W-1:0]      drain_cnt
);

    localparam int c_ptr_w = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(BUF_DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(BUF_DEPTH - 1);
    localparam logic [c_cnt_w:0]   c_depth    = (c_cnt_w + 1)'(BUF_DEPTH);

    logic [DATA_W-1:0]  r_buf [BUF_DEPTH];
    logic [c_ptr_w-1:0] r_head;
    logic [c_ptr_w-1:0] r_tail;
    logic [c_cnt_w-1:0] r_count;
    logic               r_inflight;

    logic [c_cnt_w:0]   w_occupancy;
    logic               w_rd_en;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    // Reserving a slot for the in-flight word keeps a push from ever overflowing
    assign w_occupancy = {1'b0, r_count} + {{c_cnt_w{1'b0}}, r_inflight};
    assign w_rd_en     = !rst && !bus.flush && !bus.fifo_empty && (w_occupancy < c_depth);
    assign w_valid     = (r_count != '0);
    assign w_push      = r_inflight && !bus.flush;
    assign w_pop       = w_valid && bus.m_ready && !bus.flush;

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = r_buf[r_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            drain_cnt  <= '0;
        end else if (bus.flush) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head    <= ptr_inc(r_head);
                drain_cnt <= drain_cnt + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_push) begin
            r_buf[r_tail] <= bus.fifo_data_out;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
// ============================================================================
// tb_fifo_drain_ctrl : directed and randomised-handshake bench with a behavioural FIFO
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_drain_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_drain_if #(.DATA_W(8)) bus ();
    fifo_drain_if #(.DATA_W(8)) bus4 ();
    logic [15:0] drain_cnt;
    logic [3:0]  drain_cnt4;

    fifo_drain_ctrl #(.DATA_W(8), .BUF_DEPTH(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .drain_cnt(drain_cnt)
    );

    // Narrow-counter twin sees identical inputs; only its counter width differs
    fifo_drain_ctrl #(.DATA_W(8), .BUF_DEPTH(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .drain_cnt(drain_cnt4)
    );

    logic [7:0] fq [$];
    int         fifo_level = 0;
    logic [7:0] fdata      = 8'h00;
    int         underflow  = 0;

    assign bus.fifo_empty     = (fifo_level == 0);
    assign bus.fifo_data_out  = fdata;
    assign bus4.fifo_empty    = bus.fifo_empty;
    assign bus4.fifo_data_out = bus.fifo_data_out;
    assign bus4.m_ready       = bus.m_ready;
    assign bus4.flush         = bus.flush;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            if (fq.size() == 0) underflow <= underflow + 1;
            else                fdata <= fq.pop_front();
        end
        fifo_level <= fq.size();
    end

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.flush = 1'b0; bus.m_ready = 1'b1;
        fq.delete();
        for (int i = 0; i < 5; i++) fq.push_back(8'(8'h11 + i));
        for (int c = 0; c < 3; c++) begin
            tick(); #1;
            checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
            checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
            checks++; if (bus.m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", bus.m_data); end
            checks++; if (drain_cnt !== 16'd0) begin errors++; $display("FAIL reset_drain_cnt: got %0d want 0", drain_cnt); end
        end
        tick(); rst = 1'b0; #1;
        checks++; if (bus.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL release_rd_en: got %b want 1", bus.fifo_rd_en); end
        for (int c = 1; c <= 7; c++) begin
            tick(); #1;
            if (c >= 2 && c <= 6) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== 8'(8'h11 + c - 2)) begin
                    errors++; $display("FAIL release_word cyc %0d: got v=%b d=%h want v=1 d=%h", c, bus.m_valid, bus.m_data, 8'(8'h11 + c - 2));
                end
            end else begin
                checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL release_idle cyc %0d: got v=%b want 0", c, bus.m_valid); end
            end
        end
        checks++; if (drain_cnt !== 16'd5) begin errors++; $display("FAIL release_drain_cnt: got %0d want 5", drain_cnt); end
    endtask

    task automatic test_stream16();
        int base, got, rd, bad, u0, first_rd, first_v, last_v;
        base = int'(drain_cnt); got = 0; rd = 0; bad = 0; u0 = underflow;
        first_rd = -1; first_v = -1; last_v = -1;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) fq.push_back(8'(8'h20 + i));
        for (int c = 0; c < 40; c++) begin
            tick(); #1;
            if (bus.fifo_rd_en) begin
                rd++;
                if (first_rd < 0) first_rd = c;
                if (bus.fifo_empty) bad++;
            end
            if (bus.m_valid && bus.m_ready) begin
                checks++;
                if (bus.m_data !== 8'(8'h20 + got)) begin errors++; $display("FAIL stream_data #%0d: got %h want %h", got, bus.m_data, 8'(8'h20 + got)); end
                if (first_v < 0) first_v = c;
                last_v = c;
                got++;
            end
        end
        checks++; if (got != 16) begin errors++; $display("FAIL stream_count: got %0d want 16", got); end
        checks++; if (rd != 16) begin errors++; $display("FAIL stream_rd_pulses: got %0d want 16", rd); end
        checks++; if (bad != 0 || underflow != u0) begin errors++; $display("FAIL stream_rd_empty: got %0d/%0d want 0", bad, underflow - u0); end
        checks++; if (first_v - first_rd != 2) begin errors++; $display("FAIL stream_latency: got %0d want 2", first_v - first_rd); end
        checks++; if (last_v - first_v != 15) begin errors++; $display("FAIL stream_rate: got span %0d want 15", last_v - first_v); end
        checks++; if (drain_cnt !== 16'(base + 16)) begin errors++; $display("FAIL stream_drain_cnt: got %0d want %0d", drain_cnt, base + 16); end
    endtask

    task automatic test_backpressure();
        int base, rd, vcyc, got;
        base = int'(drain_cnt); rd = 0; vcyc = 0; got = 0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) fq.push_back(8'(8'h30 + i));
        for (int c = 0; c < 15; c++) begin
            tick(); #1;
            if (bus.fifo_rd_en) rd++;
            if (bus.m_valid) begin
                vcyc++;
                checks++; if (bus.m_data !== 8'h30) begin errors++; $display("FAIL bp_hold_data: got %h want 30", bus.m_data); end
            end
        end
        checks++; if (rd != 3) begin errors++; $display("FAIL bp_rd_pulses: got %0d want 3", rd); end
        checks++; if (vcyc < 10) begin errors++; $display("FAIL bp_valid_cycles: got %0d want >=10", vcyc); end
        bus.m_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (bus.m_valid) begin
                checks++; if (bus.m_data !== 8'(8'h30 + got)) begin errors++; $display("FAIL bp_drain_data #%0d: got %h want %h", got, bus.m_data, 8'(8'h30 + got)); end
                got++;
            end
            tick(); #1;
        end
        checks++; if (got != 6) begin errors++; $display("FAIL bp_drain_count: got %0d want 6", got); end
        checks++; if (drain_cnt !== 16'(base + 6)) begin errors++; $display("FAIL bp_drain_cnt: got %0d want %0d", drain_cnt, base + 6); end
    endtask

    task automatic test_flush();
        int base, got;
        logic seen;
        base = int'(drain_cnt); got = 0; seen = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) fq.push_back(8'(8'h40 + i));
        for (int c = 0; c < 10 && !seen; c++) begin
            tick(); #1;
            if (bus.m_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1 || bus.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL flush_setup: got v=%b rd=%b want 1 1", seen, bus.fifo_rd_en); end
        // Two words buffered, third on fifo_data_out: flush now, with m_ready high
        tick(); bus.flush = 1'b1; bus.m_ready = 1'b1; fq.delete(); #1;
        checks++; if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL flush_rd_en: got %b want 0", bus.fifo_rd_en); end
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h40) begin errors++; $display("FAIL flush_pre_head: got v=%b d=%h want 1 40", bus.m_valid, bus.m_data); end
        tick(); bus.flush = 1'b0; bus.m_ready = 1'b0; #1;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.m_valid); end
        checks++; if (drain_cnt !== 16'(base)) begin errors++; $display("FAIL flush_drain_cnt: got %0d want %0d", drain_cnt, base); end
        for (int i = 0; i < 4; i++) fq.push_back(8'(8'hA0 + i));
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.m_valid && bus.m_ready) begin
                checks++; if (bus.m_data !== 8'(8'hA0 + got)) begin errors++; $display("FAIL flush_after_data #%0d: got %h want %h", got, bus.m_data, 8'(8'hA0 + got)); end
                got++;
            end
            tick(); #1;
        end
        checks++; if (got != 4) begin errors++; $display("FAIL flush_after_count: got %0d want 4", got); end
        checks++; if (drain_cnt !== 16'(base + 4)) begin errors++; $display("FAIL flush_after_cnt: got %0d want %0d", drain_cnt, base + 4); end
    endtask

    task automatic test_random();
        int base, pushed, got, u0;
        logic [7:0] exp [$];
        logic [7:0] pd, d, e;
        logic pv;
        base = int'(drain_cnt); pushed = 0; got = 0; u0 = underflow; pv = 1'b0; pd = 8'h00;
        for (int c = 0; c < 10000 && got < 1000; c++) begin
            if (pv) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== pd) begin errors++; $display("FAIL rand_stable cyc %0d: got v=%b d=%h want 1 %h", c, bus.m_valid, bus.m_data, pd); end
            end
            bus.m_ready = 1'($urandom_range(0, 1));
            if (bus.m_valid && bus.m_ready) begin
                checks++;
                if (exp.size() == 0) begin
                    errors++; $display("FAIL rand_extra: got %h want none", bus.m_data);
                end else begin
                    e = exp.pop_front();
                    if (bus.m_data !== e) begin errors++; $display("FAIL rand_data #%0d: got %h want %h", got, bus.m_data, e); end
                end
                got++;
            end
            pv = bus.m_valid && !bus.m_ready;
            pd = bus.m_data;
            if (pushed < 1000 && fq.size() < 16 && $urandom_range(0, 3) != 0) begin
                d = 8'($urandom);
                fq.push_back(d); exp.push_back(d); pushed++;
            end
            tick(); #1;
        end
        checks++; if (got != 1000 || exp.size() != 0) begin errors++; $display("FAIL rand_count: got %0d left %0d want 1000 0", got, exp.size()); end
        checks++; if (underflow != u0) begin errors++; $display("FAIL rand_underflow: got %0d want 0", underflow - u0); end
        checks++; if (drain_cnt !== 16'(base + 1000)) begin errors++; $display("FAIL rand_drain_cnt: got %0d want %0d", drain_cnt, 16'(base + 1000)); end
    endtask

    task automatic test_wrap();
        int got;
        got = 0;
        rst = 1'b1; bus.m_ready = 1'b1; bus.flush = 1'b0; fq.delete();
        tick(); tick(); #1;
        checks++; if (drain_cnt4 !== 4'd0 || drain_cnt !== 16'd0) begin errors++; $display("FAIL wrap_reset: got %0d/%0d want 0/0", drain_cnt4, drain_cnt); end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) fq.push_back(8'(8'h50 + i));
        for (int c = 0; c < 60 && got < 17; c++) begin
            if (bus.m_valid && bus.m_ready) begin
                checks++; if (bus.m_data !== 8'(8'h50 + got)) begin errors++; $display("FAIL wrap_data #%0d: got %h want %h", got, bus.m_data, 8'(8'h50 + got)); end
                got++;
            end
            if (c == 6) fq.push_back(8'h60);
            tick(); #1;
        end
        checks++; if (got != 17) begin errors++; $display("FAIL wrap_count: got %0d want 17", got); end
        checks++; if (drain_cnt !== 16'd17) begin errors++; $display("FAIL wrap_wide_cnt: got %0d want 17", drain_cnt); end
        checks++; if (drain_cnt4 !== 4'd1) begin errors++; $display("FAIL wrap_narrow_cnt: got %0d want 1", drain_cnt4); end
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_stream16();
        test_backpressure();
        test_flush();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
